// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - instruction fetch and pre-decode stage of the ARM-subset core
//
// Purpose:
//   Holds the PC, issues req/ack reads to instruction memory and registers the
//   fetched word. Presents offset (instr[23:0]) and imm_src (instr[27:26]) for
//   the immediate extender, plus pc_plus8 for the branch-target adder.
//   Redirected by branch_taken from execute.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined   : a REQ cycle counter raises the sticky fetch_fault after
//               TIMEOUT_CYCLES REQ cycles without ack; FAULT is left only by reset.
//   Undefined : no counter, no FAULT state, fetch_fault tied to 0.
//
// Parameters:
//   PC_WIDTH        PC / address width
//   RESET_PC        PC loaded on reset (bits [1:0] must be 0)
//   TIMEOUT_CYCLES  REQ cycles without ack before fault (FETCH_TIMEOUT_EN only)
//
// Ports:
//   clk            in   1         rising-edge clock
//   rst_n          in   1         asynchronous active-low reset
//   imem_req       out  1         fetch request, held until imem_ack or redirect
//   imem_addr      out  PC_WIDTH  fetch address (= pc)
//   imem_ack       in   1         read data valid this cycle
//   imem_rdata     in   32        instruction word, sampled only with imem_ack
//   stall          in   1         decode cannot accept; hold instr
//   branch_taken   in   1         redirect request, single-cycle pulse
//   branch_target  in   PC_WIDTH  redirect address; bits [1:0] forced to 0
//   instr          out  32        registered instruction
//   instr_valid    out  1         instr holds an unconsumed instruction
//   pc_plus8       out  PC_WIDTH  address of instr + 8 (wrapping)
//   offset         out  24        instr[23:0]
//   imm_src        out  2         instr[27:26]
//   fetch_fault    out  1         sticky timeout flag

module fetch_decode_stage #(
    parameter int unsigned           PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC       = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc_plus8,
    output logic [23:0]         offset,
    output logic [1:0]          imm_src,
    output logic                fetch_fault
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] PC_AHEAD   = PC_WIDTH'(8);

    // Reject configurations that cannot work at elaboration time.
    if (TIMEOUT_CYCLES == 0 || RESET_PC[1:0] != 2'b00) begin : g_bad_config
        $error("fetch_decode_stage: TIMEOUT_CYCLES must be > 0 and RESET_PC word aligned");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
`ifdef FETCH_TIMEOUT_EN
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
`else
        S_HOLD  = 2'd2
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [31:0]         instr_next;
    logic                instr_valid_next;
    logic [PC_WIDTH-1:0] pc_plus8_next;
    // Set for the single cycle after a redirect: state is already REQ but the
    // request is held low so the address never changes under a live request.
    logic                redirect;
    logic                redirect_next;
    logic                in_fault;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] timeout_cnt_next;
    logic             fault_next;

    assign in_fault = (state == S_FAULT);
`else
    assign in_fault = 1'b0;
`endif

    assign imem_req  = (state == S_REQ) && !redirect;
    assign imem_addr = pc;
    assign offset    = instr[23:0];
    assign imm_src   = instr[27:26];

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        instr_valid_next = instr_valid;
        pc_plus8_next    = pc_plus8;
        redirect_next    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout_cnt_next = timeout_cnt;
        fault_next       = fetch_fault;
`endif

        if (branch_taken && !in_fault) begin
            // Redirect wins over ack and stall; a same-cycle ack is dropped.
            pc_next          = branch_target & ALIGN_MASK;
            instr_valid_next = 1'b0;
            redirect_next    = 1'b1;
            state_next       = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            timeout_cnt_next = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    timeout_cnt_next = '0;
`endif
                end

                S_REQ: begin
                    if (redirect) begin
                        // Request gap after a redirect: nothing is outstanding.
                    end else if (imem_ack) begin
`ifdef FETCH_TIMEOUT_EN
                        timeout_cnt_next = '0;
`endif
                        // A held, unconsumed instr blocks capture; memory will
                        // re-deliver this address after the stall.
                        if (!stall || !instr_valid) begin
                            instr_next       = imem_rdata;
                            instr_valid_next = 1'b1;
                            pc_plus8_next    = pc + PC_AHEAD;
                            pc_next          = pc + PC_STEP;
                        end
                        if (stall) begin
                            state_next = S_HOLD;
                        end
                    end else begin
                        if (!stall) begin
                            instr_valid_next = 1'b0;
                        end
`ifdef FETCH_TIMEOUT_EN
                        if (timeout_cnt == CNT_LAST) begin
                            fault_next       = 1'b1;
                            instr_valid_next = 1'b0;
                            state_next       = S_FAULT;
                        end else begin
                            timeout_cnt_next = timeout_cnt + CNT_W'(1);
                        end
`endif
                    end
                end

                S_HOLD: begin
                    // Decode takes instr in the releasing cycle.
                    if (!stall) begin
                        instr_valid_next = 1'b0;
                        state_next       = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                        timeout_cnt_next = '0;
`endif
                    end
                end

`ifdef FETCH_TIMEOUT_EN
                S_FAULT: begin
                    instr_valid_next = 1'b0;
                end
`endif

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_plus8    <= '0;
            redirect    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= instr_valid_next;
            pc_plus8    <= pc_plus8_next;
            redirect    <= redirect_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            fetch_fault <= 1'b0;
        end else begin
            timeout_cnt <= timeout_cnt_next;
            fetch_fault <= fault_next;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - self-checking bench for fetch_decode_stage

module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus8;
    logic [23:0] offset;
    logic [1:0]  imm_src;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_decode_stage #(
        .PC_WIDTH      (32),
        .RESET_PC      (32'h100),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_plus8     (pc_plus8),
        .offset       (offset),
        .imm_src      (imm_src),
        .fetch_fault  (fetch_fault)
    );

    // Instruction memory contents: a few fixed words, hashed elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hE3A0_1005;
            32'h0000_0104: return 32'hE591_2004;
            32'h0000_0200: return 32'hEAFF_FFFE;
            default:       return (a * 32'h9E37_79B1) ^ 32'hA5C3_5A3C;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference model: program-order view of the fetch stream.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p8;
    logic        m_valid;
    logic        m_req;
    logic        m_parked;
    logic        model_on;

    task automatic model_reset();
        m_pc     = 32'h100;
        m_instr  = 32'h0;
        m_p8     = 32'h0;
        m_valid  = 1'b0;
        m_req    = 1'b0;
        m_parked = 1'b0;
    endtask

    task automatic model_step();
        logic nreq;
        nreq = m_req;
        if (branch_taken) begin
            m_pc     = branch_target & ~32'd3;
            m_valid  = 1'b0;
            m_parked = 1'b0;
            nreq     = 1'b0;
        end else if (m_req) begin
            if (imem_ack) begin
                if (!stall || !m_valid) begin
                    m_instr = mem_word(m_pc);
                    m_valid = 1'b1;
                    m_p8    = m_pc + 32'd8;
                    m_pc    = m_pc + 32'd4;
                end
                if (stall) begin
                    m_parked = 1'b1;
                    nreq     = 1'b0;
                end
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end else if (m_parked) begin
            if (!stall) begin
                m_parked = 1'b0;
                m_valid  = 1'b0;
                nreq     = 1'b1;
            end
        end else begin
            nreq = 1'b1;
        end
        m_req = nreq;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_req",      {31'h0, imem_req},    {31'h0, m_req});
        chk("m_addr",     imem_addr,            m_pc);
        chk("m_valid",    {31'h0, instr_valid}, {31'h0, m_valid});
        chk("m_instr",    instr,                m_instr);
        chk("m_pc_plus8", pc_plus8,             m_p8);
        chk("m_offset",   {8'h0, offset},       {8'h0, m_instr[23:0]});
        chk("m_imm_src",  {30'h0, imm_src},     {30'h0, m_instr[27:26]});
        chk("m_fault",    {31'h0, fetch_fault}, 32'h0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (model_on) check_model();
    endtask

    initial begin
        int streak;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_on      = 1'b1;
        model_reset();

        // 1: reset state and first request
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      {31'h0, imem_req},    32'h0);
        chk("rst_valid",    {31'h0, instr_valid}, 32'h0);
        chk("rst_instr",    instr,                32'h0);
        chk("rst_pc_plus8", pc_plus8,             32'h0);
        chk("rst_offset",   {8'h0, offset},       32'h0);
        chk("rst_imm_src",  {30'h0, imm_src},     32'h0);
        chk("rst_fault",    {31'h0, fetch_fault}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("t1_req",  {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr,         32'h100);

        // 2: back-to-back acks
        imem_ack = 1'b1;
        tick();
        chk("t2a_instr",   instr,            32'hE3A0_1005);
        chk("t2a_imm_src", {30'h0, imm_src}, 32'h0);
        chk("t2a_offset",  {8'h0, offset},   32'h00A0_1005);
        chk("t2a_p8",      pc_plus8,         32'h108);
        chk("t2a_addr",    imem_addr,        32'h104);
        tick();
        chk("t2b_instr",   instr,            32'hE591_2004);
        chk("t2b_imm_src", {30'h0, imm_src}, 32'h1);
        chk("t2b_offset",  {8'h0, offset},   32'h0091_2004);
        chk("t2b_p8",      pc_plus8,         32'h10C);
        chk("t2b_addr",    imem_addr,        32'h108);

        // 3: three stall cycles with a valid instr held
        stall = 1'b1;
        tick();
        chk("t3_req0",   {31'h0, imem_req},    32'h0);
        chk("t3_instr0", instr,                32'hE591_2004);
        chk("t3_valid0", {31'h0, instr_valid}, 32'h1);
        imem_ack = 1'b0;
        tick();
        tick();
        chk("t3_req2",   {31'h0, imem_req}, 32'h0);
        chk("t3_instr2", instr,             32'hE591_2004);
        stall = 1'b0;
        tick();
        chk("t3_resume_req",  {31'h0, imem_req}, 32'h1);
        chk("t3_resume_addr", imem_addr,         32'h108);
        imem_ack = 1'b1;
        tick();
        chk("t3_p8",   pc_plus8,  32'h110);
        chk("t3_addr", imem_addr, 32'h10C);

        // 4: branch in the same cycle as an ack
        branch_taken  = 1'b1;
        branch_target = 32'h203;
        tick();
        chk("t4_valid", {31'h0, instr_valid}, 32'h0);
        chk("t4_gap",   {31'h0, imem_req},    32'h0);
        chk("t4_addr",  imem_addr,            32'h200);
        branch_taken = 1'b0;
        tick();
        chk("t4_req",  {31'h0, imem_req},    32'h1);
        chk("t4_addr2", imem_addr,           32'h200);
        chk("t4_valid2", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("t4_instr",   instr,            32'hEAFF_FFFE);
        chk("t4_imm_src", {30'h0, imm_src}, 32'h2);
        chk("t4_offset",  {8'h0, offset},   32'h00FF_FFFE);
        chk("t4_p8",      pc_plus8,         32'h208);
        imem_ack = 1'b0;

        // 5: wrap of pc+4 / pc+8
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("t5_req",  {31'h0, imem_req}, 32'h1);
        chk("t5_addr", imem_addr,         32'hFFFF_FFFC);
        imem_ack = 1'b1;
        tick();
        chk("t5_wrap_addr", imem_addr, 32'h0);
        chk("t5_wrap_p8",   pc_plus8,  32'h4);
        imem_ack = 1'b0;

`ifndef FETCH_TIMEOUT_EN
        // Without the timeout feature a request waits forever.
        repeat (20) tick();
        chk("nto_req",   {31'h0, imem_req},    32'h1);
        chk("nto_fault", {31'h0, fetch_fault}, 32'h0);
`endif

        // Reset mid-request drops req at once; a late ack in IDLE is ignored.
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, imem_req}, 32'h0);
        chk("mid_rst_instr", instr,             32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        tick();
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("late_ack_req",   {31'h0, imem_req},    32'h1);

        // Randomized traffic against the model.
        streak = 0;
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(0, 99) < 30);
            branch_taken = ($urandom_range(0, 99) < 7);
            branch_target = $urandom;
            imem_ack     = ($urandom_range(0, 99) < 60);
            if (streak >= 8) imem_ack = 1'b1;
            if (m_req && !imem_ack) streak++;
            else if (imem_ack) streak = 0;
            tick();
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // 6: timeout fault after 16 REQ cycles without ack
        model_on = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_req_start", {31'h0, imem_req}, 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t6_req_wait",   {31'h0, imem_req},    32'h1);
            chk("t6_fault_wait", {31'h0, fetch_fault}, 32'h0);
        end
        tick();
        chk("t6_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t6_req",   {31'h0, imem_req},    32'h0);
        chk("t6_valid", {31'h0, instr_valid}, 32'h0);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("t6_br_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t6_br_req",   {31'h0, imem_req},    32'h0);
        chk("t6_br_addr",  imem_addr,            32'h100);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_fault", {31'h0, fetch_fault}, 32'h0);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
